csa4_avg_scheduler: RTL and testbench
=====================================

Name: csa4_avg_scheduler

Overview:
- Shares one 4-operand, 5-bit carry-save compressor between two interpolation requesters: green-plane and red/blue-plane neighbour averaging.
- Each request carries four W-bit neighbour pixels.
- The block round-robin arbitrates, drives the compressor operands, captures its two W+2-bit partial vectors, and resolves them with a final carry-propagate add.
- Returns the 4-neighbour sum and the rounded average with a valid/ready handshake.
- Sits between the demosaic window buffer and the pixel writer.

Parameters:
- W, 5, operand width. Must match the shared compressor.
- ROUND, 1. 1 = average rounds half-up (sum+2)>>2; 0 = truncate sum>>2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 (green) has operands
- req0_ready  out  1  requester 0 operands accepted this edge
- req0_ops  in  4*W  requester 0 operands {D,C,B,A}, A at LSBs
- req1_valid  in  1  requester 1 (red/blue) has operands
- req1_ready  out  1  requester 1 operands accepted this edge
- req1_ops  in  4*W  requester 1 operands, same packing
- csa_a, csa_b, csa_c, csa_d  out  W each  operands to shared compressor
- csa_out1, csa_out2  in  W+2 each  compressor partial vectors (combinational from csa_a..d)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  W+2  A+B+C+D
- out_avg  out  W  rounded average
- out_src  out  1  requester id of result
- busy  out  1  any pipeline stage occupied

Behaviour:
- Reset: synchronous, active-high on rst.
  - All stage valids, out_valid, busy cleared to 0.
  - out_sum, out_avg, out_src, csa_a..d cleared to 0.
  - last_grant set to 1, so req0 wins the first contention.
  - A reset mid-operation discards every in-flight entry, with no output produced.
- Pipeline: three registered stages with per-stage valid.
  - S1 operand register; it drives csa_a..d directly.
  - S2 captures csa_out1/csa_out2 and src.
  - S3 holds out_sum/out_avg/out_src; S3 valid is out_valid.
- Stage advance: stage n loads when its upstream is valid and (stage n empty, or stage n+1 loads this edge). S3 frees when out_valid & out_ready.
- Bubbles collapse. Throughput is 1 result/cycle when out_ready=1.
- Latency: request accepted at edge t loads S1 at t, S2 at t+1, S3 at t+2. out_valid is visible after edge t+2.
- Arbitration (combinational grant, s1_can_load = S1 loads this edge):
  - Only reqX_valid: grant X.
  - Both valid: grant the requester that is not last_grant.
  - reqX_ready = grant==X & s1_can_load & ~rst. At most one ready is high per cycle.
  - last_grant updates only on an accepted handshake.
- Requester rules: must hold reqX_ops stable while valid & ~ready. Dropping valid without a handshake is allowed and leaves no state change.
- Arithmetic:
  - S3 computes the W+3-bit add of csa_out1+csa_out2, and out_sum keeps the low W+2 bits. Overflow is impossible: max sum is 4*(2^W-1).
  - out_avg = (sum + (ROUND?2:0)) >> 2, truncated to W bits; the maximum fits exactly.
- Backpressure: while out_valid & ~out_ready, S3 holds every output bit stable. The pipeline fills to 3 entries, then both reqX_ready drop.
- Ordering: results are delivered in acceptance order, never dropped or duplicated.
- busy = S1v | S2v | S3v.

Test Plan:
- Single request: req0 ops A=10,B=20,C=30,D=31, out_ready=1 → out_valid one cycle, two edges after acceptance; out_sum=91, out_avg=23, out_src=0, busy returns 0.
- Contention: both valid continuously for 6 cycles, out_ready=1 → grants 0,1,0,1,0,1; out_src alternates identically; one result per cycle.
- Backpressure: req0 streams ops (k,k,k,k) for k=1..6; out_ready=0 for cycles 3–8 → req0_ready low once 3 entries are held; outputs stable while stalled; sums 4,8,…,24 delivered in order, none lost.
- Extremes: all ops 31 → out_sum=124, out_avg=31. All ops 0 → out_sum=0, out_avg=0.
- Rounding: ops 1,1,1,0 → out_sum=3; out_avg=1 with ROUND=1, 0 with ROUND=0.
- Mid-operation reset: rst high for 1 cycle with 3 entries in flight → next cycle out_valid=0, busy=0, no stale result. When both requesters are valid afterwards, req0 is granted first.

Source files
------------

// File: rtl/csa4_avg_scheduler.sv
// csa4_avg_scheduler
//   Shares one 4-operand carry-save compressor between two neighbour-averaging
//   requesters (0 = green plane, 1 = red/blue plane). Round-robin arbitration
//   feeds a 3-stage pipeline:
//     S1 operand register, which drives csa_a..csa_d
//     S2 captures the compressor partial vectors csa_out1/csa_out2
//     S3 resolves them with a carry-propagate add (sum, average, source id)
//   Ports:
//     clk, rst                 clock; synchronous active-high reset
//     reqN_valid/ready/ops     requester handshakes, ops = {D,C,B,A}
//     csa_a..csa_d             operands to the shared compressor
//     csa_out1, csa_out2       compressor partial vectors (combinational)
//     out_valid/out_ready      result handshake
//     out_sum, out_avg, out_src  A+B+C+D, rounded average, requester id
//     busy                     any pipeline stage occupied
module csa4_avg_scheduler #(
  parameter int W     = 5,
  parameter bit ROUND = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [4*W-1:0] req0_ops,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [4*W-1:0] req1_ops,
  output logic [W-1:0]   csa_a,
  output logic [W-1:0]   csa_b,
  output logic [W-1:0]   csa_c,
  output logic [W-1:0]   csa_d,
  input  logic [W+1:0]   csa_out1,
  input  logic [W+1:0]   csa_out2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W+1:0]   out_sum,
  output logic [W-1:0]   out_avg,
  output logic           out_src,
  output logic           busy
);

  localparam logic [W+2:0] RND = ROUND ? (W+3)'(2) : '0;

  logic           s1v, s2v;
  logic           s1_src, s2_src;
  logic [W+1:0]   s2_p1, s2_p2;
  logic           last_grant;

  logic           s3_load, s2_load, s1_can_load;
  logic           any_req, grant, accept;
  logic [4*W-1:0] grant_ops;
  logic [W+2:0]   full_sum, rnd_sum;

  // Each stage advances when its successor is empty or draining this edge,
  // so bubbles collapse and a full pipe still streams at 1/cycle.
  assign s3_load     = s2v & (~out_valid | out_ready);
  assign s2_load     = s1v & (~s2v | s3_load);
  assign s1_can_load = ~s1v | s2_load;

  // Under contention the requester not granted last time wins.
  assign any_req    = req0_valid | req1_valid;
  assign grant      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign accept     = any_req & s1_can_load & ~rst;
  assign req0_ready = accept & ~grant;
  assign req1_ready = accept & grant;
  assign grant_ops  = grant ? req1_ops : req0_ops;

  // W+3 bits holds 4*(2^W-1) plus the rounding constant without wrap.
  assign full_sum = {1'b0, s2_p1} + {1'b0, s2_p2};
  assign rnd_sum  = full_sum + RND;

  assign busy = s1v | s2v | out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1v        <= 1'b0;
      s2v        <= 1'b0;
      out_valid  <= 1'b0;
      s1_src     <= 1'b0;
      s2_src     <= 1'b0;
      s2_p1      <= '0;
      s2_p2      <= '0;
      csa_a      <= '0;
      csa_b      <= '0;
      csa_c      <= '0;
      csa_d      <= '0;
      out_sum    <= '0;
      out_avg    <= '0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        s1v                        <= 1'b1;
        s1_src                     <= grant;
        {csa_d, csa_c, csa_b, csa_a} <= grant_ops;
        last_grant                 <= grant;
      end else if (s2_load) begin
        s1v <= 1'b0;
      end

      if (s2_load) begin
        s2v    <= 1'b1;
        s2_p1  <= csa_out1;
        s2_p2  <= csa_out2;
        s2_src <= s1_src;
      end else if (s3_load) begin
        s2v <= 1'b0;
      end

      // S3 only changes on load, so a stalled result holds every bit.
      if (s3_load) begin
        out_valid <= 1'b1;
        out_sum   <= (W+2)'(full_sum);
        out_avg   <= W'(rnd_sum >> 2);
        out_src   <= s2_src;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csa4_avg_scheduler.sv
module tb_csa4_avg_scheduler;
  localparam int W = 5;

  typedef struct packed { logic src; logic [W-1:0] a, b, c, d; } ent_t;
  typedef struct packed { logic src; logic [W+1:0] sum; logic [W-1:0] avg; logic [W-1:0] tavg; } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0;
  logic [4*W-1:0] req0_ops = '0, req1_ops = '0;

  logic req0_ready, req1_ready, out_valid, out_src, busy;
  logic [W-1:0] csa_a, csa_b, csa_c, csa_d, out_avg;
  logic [W+1:0] csa_out1, csa_out2, out_sum;

  logic t_req0_ready, t_req1_ready, t_out_valid, t_out_src, t_busy;
  logic [W-1:0] t_csa_a, t_csa_b, t_csa_c, t_csa_d, t_out_avg;
  logic [W+1:0] t_csa_out1, t_csa_out2, t_out_sum;

  int checks = 0;
  int passes = 0;

  ent_t exp_q[$];
  res_t obs_q[$], mdl_q[$];
  logic model_last = 1'b1;

  always #5 clk = ~clk;

  // Shared 4:2 compressor model: two 3:2 carry-save levels.
  function automatic logic [2*(W+2)-1:0] csa42(input logic [W-1:0] a, b, c, d);
    logic [W+1:0] s1, c1, s2, c2, x;
    x  = {2'b0, d};
    s1 = {2'b0, a ^ b ^ c};
    c1 = {1'b0, (a & b) | (a & c) | (b & c), 1'b0};
    s2 = s1 ^ c1 ^ x;
    c2 = ((s1 & c1) | (s1 & x) | (c1 & x)) << 1;
    return {c2, s2};
  endfunction

  assign {csa_out2, csa_out1}     = csa42(csa_a, csa_b, csa_c, csa_d);
  assign {t_csa_out2, t_csa_out1} = csa42(t_csa_a, t_csa_b, t_csa_c, t_csa_d);

  csa4_avg_scheduler #(.W(W), .ROUND(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ops(req0_ops),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ops(req1_ops),
    .csa_a(csa_a), .csa_b(csa_b), .csa_c(csa_c), .csa_d(csa_d),
    .csa_out1(csa_out1), .csa_out2(csa_out2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_avg(out_avg), .out_src(out_src), .busy(busy));

  csa4_avg_scheduler #(.W(W), .ROUND(1'b0)) dut_t (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(t_req0_ready), .req0_ops(req0_ops),
    .req1_valid(req1_valid), .req1_ready(t_req1_ready), .req1_ops(req1_ops),
    .csa_a(t_csa_a), .csa_b(t_csa_b), .csa_c(t_csa_c), .csa_d(t_csa_d),
    .csa_out1(t_csa_out1), .csa_out2(t_csa_out2),
    .out_valid(t_out_valid), .out_ready(out_ready),
    .out_sum(t_out_sum), .out_avg(t_out_avg), .out_src(t_out_src), .busy(t_busy));

  function automatic logic [4*W-1:0] pk(input int a, b, c, d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic ent_t mk(input logic src, input logic [4*W-1:0] ops);
    ent_t e;
    e.src = src;
    e.a = ops[W-1:0];
    e.b = ops[2*W-1:W];
    e.c = ops[3*W-1:2*W];
    e.d = ops[4*W-1:3*W];
    return e;
  endfunction

  // Reference: plain integer sum, half-up and truncating averages.
  function automatic res_t model(input ent_t e);
    res_t r;
    int s;
    s      = int'(e.a) + int'(e.b) + int'(e.c) + int'(e.d);
    r.src  = e.src;
    r.sum  = (W+2)'(s);
    r.avg  = W'((s + 2) / 4);
    r.tavg = W'(s / 4);
    return r;
  endfunction

  // Scoreboard: acceptances queue in order; each delivered result is paired
  // with the oldest accepted request. Reset discards everything in flight.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_last = 1'b1;
    end else begin
      if (out_valid && out_ready) begin
        obs_q.push_back({out_src, out_sum, out_avg, t_out_avg});
        if (exp_q.size() > 0) mdl_q.push_back(model(exp_q.pop_front()));
        else                  mdl_q.push_back('x);
      end
      if (req0_valid && req0_ready) begin exp_q.push_back(mk(1'b0, req0_ops)); model_last = 1'b0; end
      if (req1_valid && req1_ready) begin exp_q.push_back(mk(1'b1, req1_ops)); model_last = 1'b1; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_results();
    obs_q.delete();
    mdl_q.delete();
  endtask

  task automatic send_one(input logic src, input logic [4*W-1:0] ops, output bit ok);
    out_ready = 1'b1;
    if (src) begin req1_valid = 1'b1; req1_ops = ops; end
    else     begin req0_valid = 1'b1; req0_ops = ops; end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (src ? req1_ready : req0_ready) ok = 1'b1;
      tick();
      if (ok) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic drain(output bit ok);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      tick();
    end
    ok = !busy && (exp_q.size() == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req0_ops = pk(1, 2, 3, 4); out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++;
    if ({out_sum, out_avg, out_src} !== '0) $display("FAIL reset_outputs: got sum=%0d avg=%0d src=%0d want 0", out_sum, out_avg, out_src);
    else passes++;
    checks++;
    if ({csa_a, csa_b, csa_c, csa_d} !== '0) $display("FAIL reset_csa: got %h want 0", {csa_a, csa_b, csa_c, csa_d});
    else passes++;
    checks++; if (req0_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req0_ready); else passes++;
    req0_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic exp_g;
    bit ok;
    rst = 1'b1; tick(); rst = 1'b0;
    clear_results();
    out_ready = 1'b1;
    req0_ops = 20'($urandom); req1_ops = 20'($urandom);
    exp_g = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req0_valid = (i < 6);
      req1_valid = (i < 6);
      #1;
      if (i < 6) begin
        checks++;
        if ({req0_ready, req1_ready} !== (exp_g ? 2'b01 : 2'b10))
          $display("FAIL cont_grant[%0d]: got r0=%b r1=%b want grant %0d", i, req0_ready, req1_ready, exp_g);
        else passes++;
      end
      tick();
      if (i < 6) begin
        if (exp_g) req1_ops = 20'($urandom); else req0_ops = 20'($urandom);
        exp_g = ~exp_g;
      end
      checks++;
      if (out_valid !== (i >= 2)) $display("FAIL cont_out_valid[%0d]: got %b want %b", i, out_valid, i >= 2);
      else passes++;
      if (i >= 2) begin
        checks++;
        if (out_src !== 1'((i - 2) & 1)) $display("FAIL cont_src[%0d]: got %b want %0d", i, out_src, (i - 2) & 1);
        else passes++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL cont_end_valid: got %b want 0", out_valid); else passes++;
    drain(ok);
    checks++; if (!ok) $display("FAIL cont_drain: pipeline still busy=%b pending=%0d", busy, exp_q.size()); else passes++;
    checks++; if (obs_q.size() !== 6) $display("FAIL cont_count: got %0d want 6", obs_q.size()); else passes++;
    while (obs_q.size() > 0) begin
      res_t o, m;
      o = obs_q.pop_front(); m = mdl_q.pop_front();
      checks++;
      if (o !== m) $display("FAIL cont_result: got src=%0d sum=%0d avg=%0d want src=%0d sum=%0d avg=%0d", o.src, o.sum, o.avg, m.src, m.sum, m.avg);
      else passes++;
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_ops = pk(10, 20, 30, 31);
    #1;
    checks++; if (req0_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", req0_ready); else passes++;
    tick();
    req0_valid = 1'b0;
    checks++;
    if ({out_valid, busy} !== 2'b01) $display("FAIL single_t0: got valid=%b busy=%b want 0/1", out_valid, busy);
    else passes++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL single_t1: got valid=%b want 0", out_valid); else passes++;
    tick();
    checks++;
    if ({out_valid, out_sum, out_avg, out_src} !== {1'b1, 7'd91, 5'd23, 1'b0})
      $display("FAIL single_result: got valid=%b sum=%0d avg=%0d src=%0d want 1 91 23 0", out_valid, out_sum, out_avg, out_src);
    else passes++;
    tick();
    checks++;
    if ({out_valid, busy} !== 2'b00) $display("FAIL single_idle: got valid=%b busy=%b want 0/0", out_valid, busy);
    else passes++;
  endtask

  task automatic test_backpressure();
    int k, occ;
    logic stalled, acc;
    logic [W+1:0] s_sum;
    logic [W-1:0] s_avg;
    logic s_src;
    bit ok;
    clear_results();
    k = 1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_ops = pk(1, 1, 1, 1);
    for (int c = 1; c <= 40 && (k <= 6 || busy); c++) begin
      out_ready = !(c >= 3 && c <= 8);
      #1;
      occ = exp_q.size();
      checks++;
      if (req0_ready !== (req0_valid && (occ < 3 || out_ready)))
        $display("FAIL bp_ready[c%0d]: got %b want %b (held=%0d)", c, req0_ready, req0_valid && (occ < 3 || out_ready), occ);
      else passes++;
      stalled = out_valid && !out_ready;
      s_sum = out_sum; s_avg = out_avg; s_src = out_src;
      acc = req0_valid && req0_ready;
      tick();
      if (stalled) begin
        checks++;
        if ({out_valid, out_sum, out_avg, out_src} !== {1'b1, s_sum, s_avg, s_src})
          $display("FAIL bp_hold[c%0d]: got valid=%b sum=%0d avg=%0d want 1 %0d %0d", c, out_valid, out_sum, out_avg, s_sum, s_avg);
        else passes++;
      end
      if (acc) begin
        k++;
        if (k <= 6) req0_ops = pk(k, k, k, k);
        else        req0_valid = 1'b0;
      end
    end
    drain(ok);
    checks++; if (k !== 7 || !ok) $display("FAIL bp_timeout: accepted=%0d want 6, busy=%b", k - 1, busy); else passes++;
    checks++; if (obs_q.size() !== 6) $display("FAIL bp_count: got %0d want 6", obs_q.size()); else passes++;
    for (int i = 1; obs_q.size() > 0; i++) begin
      res_t o, m;
      o = obs_q.pop_front(); m = mdl_q.pop_front();
      checks++;
      if (o !== m || o.sum !== 7'(4 * i))
        $display("FAIL bp_result[%0d]: got sum=%0d avg=%0d want sum=%0d avg=%0d", i, o.sum, o.avg, m.sum, m.avg);
      else passes++;
    end
  endtask

  task automatic test_extremes();
    bit ok1, ok2;
    send_one(1'b0, pk(31, 31, 31, 31), ok1);
    wait_out(ok2);
    checks++;
    if (!(ok1 && ok2) || {out_sum, out_avg, t_out_avg} !== {7'd124, 5'd31, 5'd31})
      $display("FAIL ext_max: got sum=%0d avg=%0d tavg=%0d want 124 31 31", out_sum, out_avg, t_out_avg);
    else passes++;
    tick();
    send_one(1'b1, pk(0, 0, 0, 0), ok1);
    wait_out(ok2);
    checks++;
    if (!(ok1 && ok2) || {out_sum, out_avg, out_src} !== {7'd0, 5'd0, 1'b1})
      $display("FAIL ext_zero: got sum=%0d avg=%0d src=%0d want 0 0 1", out_sum, out_avg, out_src);
    else passes++;
    tick();
  endtask

  task automatic test_rounding();
    bit ok1, ok2;
    send_one(1'b0, pk(1, 1, 1, 0), ok1);
    wait_out(ok2);
    checks++;
    if (!(ok1 && ok2) || {out_sum, out_avg, t_out_avg} !== {7'd3, 5'd1, 5'd0})
      $display("FAIL round: got sum=%0d avg=%0d tavg=%0d want 3 1 0", out_sum, out_avg, t_out_avg);
    else passes++;
    tick();
  endtask

  task automatic test_mid_reset();
    logic a0, a1;
    bit ok;
    out_ready = 1'b0;
    req0_ops = 20'($urandom); req1_ops = 20'($urandom);
    // Two contended accepts then one req0-only, so req0 holds the last grant.
    for (int i = 0; i < 10 && exp_q.size() < 3; i++) begin
      req0_valid = 1'b1;
      req1_valid = (exp_q.size() < 2);
      #1;
      a0 = req0_ready; a1 = req1_ready;
      tick();
      if (a0) req0_ops = 20'($urandom);
      if (a1) req1_ops = 20'($urandom);
    end
    checks++;
    if (exp_q.size() !== 3 || {busy, out_valid} !== 2'b11)
      $display("FAIL mr_fill: got held=%0d busy=%b valid=%b want 3 1 1", exp_q.size(), busy, out_valid);
    else passes++;
    clear_results();
    rst = 1'b1; out_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL mr_ready_in_rst: got %b%b want 00", req0_ready, req1_ready);
    else passes++;
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, busy} !== 2'b00) $display("FAIL mr_flush: got valid=%b busy=%b want 0/0", out_valid, busy);
    else passes++;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL mr_grant: got r0=%b r1=%b want req0", req0_ready, req1_ready);
    else passes++;
    tick();
    drain(ok);
    checks++;
    if (!ok || obs_q.size() !== 1) $display("FAIL mr_count: got %0d results busy=%b want 1", obs_q.size(), busy);
    else passes++;
    while (obs_q.size() > 0) begin
      res_t o, m;
      o = obs_q.pop_front(); m = mdl_q.pop_front();
      checks++;
      if (o !== m || o.src !== 1'b0) $display("FAIL mr_result: got src=%0d sum=%0d want src=0 sum=%0d", o.src, o.sum, m.sum);
      else passes++;
    end
  endtask

  task automatic test_random();
    logic a0, a1;
    int occ;
    bit ok;
    clear_results();
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      occ = exp_q.size();
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      checks++;
      if ((req0_ready && req1_ready) || (req0_ready && !req0_valid) || (req1_ready && !req1_valid) ||
          ((req0_ready || req1_ready) !== ((req0_valid || req1_valid) && (occ < 3 || out_ready))) ||
          (req0_valid && req1_valid && (req0_ready || req1_ready) && req1_ready !== !model_last))
        $display("FAIL rnd_arb[%0d]: got r0=%b r1=%b v0=%b v1=%b held=%0d last=%b", i, req0_ready, req1_ready, req0_valid, req1_valid, occ, model_last);
      else passes++;
      tick();
      if (!req0_valid || a0) begin req0_valid = ($urandom_range(0, 2) != 0); req0_ops = 20'($urandom); end
      if (!req1_valid || a1) begin req1_valid = ($urandom_range(0, 2) != 0); req1_ops = 20'($urandom); end
    end
    drain(ok);
    checks++; if (!ok) $display("FAIL rnd_drain: busy=%b pending=%0d", busy, exp_q.size()); else passes++;
    while (obs_q.size() > 0) begin
      res_t o, m;
      o = obs_q.pop_front(); m = mdl_q.pop_front();
      checks++;
      if (o !== m) $display("FAIL rnd_result: got src=%0d sum=%0d avg=%0d tavg=%0d want src=%0d sum=%0d avg=%0d tavg=%0d",
                            o.src, o.sum, o.avg, o.tavg, m.src, m.sum, m.avg, m.tavg);
      else passes++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_extremes();
    test_rounding();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
    $fatal(1);
  end

endmodule
